// File: rtl/irq_gateway_if.sv
// Bundle of per-source interrupt lines between device side and the PLIC-facing gateway.
interface irq_gateway_if #(
  parameter int NumIrqs = 32
) ();

  logic [NumIrqs-1:0] irq_i;
  logic [NumIrqs-1:0] edge_mode_i;
  logic [NumIrqs-1:0] ack_i;
  logic [NumIrqs-1:0] interrupts_o;
  logic [NumIrqs-1:0] edge_trigger_o;

  modport master (
    output irq_i,
    output edge_mode_i,
    output ack_i,
    input  interrupts_o,
    input  edge_trigger_o
  );

  modport slave (
    input  irq_i,
    input  edge_mode_i,
    input  ack_i,
    output interrupts_o,
    output edge_trigger_o
  );

endinterface

// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronizes raw device lines and turns edge sources into held requests.
// Optional per-source glitch filter is compiled in with IRQ_GATEWAY_FILTER_EN.
module irq_gateway #(
  parameter int NumIrqs      = 32,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  irq_gateway_if.slave bus
);

  logic [NumIrqs-1:0] sync_q [SyncStages];
  logic [NumIrqs-1:0] sync_s;
  logic [NumIrqs-1:0] filt;
  logic [NumIrqs-1:0] filt_q;
  logic [NumIrqs-1:0] pending_q;
  logic [NumIrqs-1:0] rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.irq_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SyncStages-1];

`ifdef IRQ_GATEWAY_FILTER_EN
  localparam logic [7:0] FilterMax = 8'(FilterCycles);

  logic [7:0]         cnt_q [NumIrqs];
  logic [NumIrqs-1:0] filt_r;

  // The filtered value flips on the edge where the run of differing samples reaches FilterMax.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NumIrqs; n++) begin
        cnt_q[n] <= '0;
      end
      filt_r <= '0;
    end else begin
      for (int n = 0; n < NumIrqs; n++) begin
        if (sync_s[n] == filt_r[n]) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] + 8'd1 >= FilterMax) begin
          cnt_q[n]  <= FilterMax;
          filt_r[n] <= sync_s[n];
        end else begin
          cnt_q[n] <= cnt_q[n] + 8'd1;
        end
      end
    end
  end

  assign filt = filt_r;
`else
  assign filt = sync_s;
`endif

  assign rise = filt & ~filt_q;

  // filt_q is both the edge detector history and the registered level output.
  // A new edge wins over a simultaneous ack so the request is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q    <= '0;
      pending_q <= '0;
    end else begin
      filt_q    <= filt;
      pending_q <= (pending_q & ~(bus.ack_i & bus.edge_mode_i))
                 | (rise & bus.edge_mode_i);
    end
  end

  assign bus.interrupts_o   = (bus.edge_mode_i & pending_q) | (~bus.edge_mode_i & filt_q);
  assign bus.edge_trigger_o = '0;

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 Parameter NumIrqs, default 32, number of interrupt sources (index 0 unused by convention, still implemented).
REQ-002 Parameter SyncStages, default 2, flops in each input synchronizer chain; legal range 2..4.
REQ-003 Parameter FilterCycles, default 4, stable-sample count required by the glitch filter; legal range 1..255.
REQ-004 Port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous and active-high.
REQ-006 Port irq_i  input  NumIrqs  raw device interrupt lines, asynchronous to clk_i.
REQ-007 Port edge_mode_i  input  NumIrqs  per-source mode, 1 = edge-triggered, 0 = level-triggered; static after reset.
REQ-008 Port ack_i  input  NumIrqs  one-cycle pulse per source from the PLIC when it has latched an edge request.
REQ-009 Port interrupts_o  output  NumIrqs  conditioned requests to the PLIC interrupts input.
REQ-010 Port edge_trigger_o  output  NumIrqs  all zero; the gateway performs edge handling, so the PLIC treats every output as level.

Function
REQ-011 Each irq_i bit SHALL pass through a SyncStages-deep flop chain; the last stage is the synchronized value s[n].
REQ-012 Without the filter, the filtered value f[n] SHALL equal s[n].
REQ-013 Level source: interrupts_o[n] SHALL equal f[n], registered, giving an irq_i-to-output latency of SyncStages+1 cycles (filter off).
REQ-014 Edge source: a register f_q[n] holds the previous f[n]; a rising edge is f[n] & ~f_q[n].
REQ-015 Edge source: a rising edge SHALL set pending[n] on the next cycle; interrupts_o[n] = pending[n].
REQ-016 Edge source: ack_i[n] SHALL clear pending[n] on the next cycle.
REQ-017 A rising edge and ack_i[n] in the same cycle SHALL leave pending[n] set; the new edge is not lost.
REQ-018 Further edges while pending[n] is already set SHALL merge into the single pending request; no count is kept.
REQ-019 ack_i[n] on a level source, or on an edge source with pending[n] clear, SHALL have no effect.
REQ-020 Falling edges SHALL never set pending.
REQ-021 If edge_mode_i[n] changes after reset, behaviour is undefined; the bench does not exercise it.
REQ-022 All sources are independent; simultaneous events on different bits SHALL not interact.

Reset
REQ-023 While rst_i is high, the synchronizer flops, f_q, pending, filter counters and filter outputs SHALL be cleared to 0.
REQ-024 interrupts_o SHALL read 0 from the cycle after rst_i is first sampled high until a new request is qualified after reset.
REQ-025 Reset asserted mid-operation SHALL discard pending edges and partially counted filter runs.
REQ-026 An input already high when reset deasserts: a level source asserts after the normal latency; an edge source sees a rising edge, because f_q resets to 0.

Configuration
REQ-027 Macro IRQ_GATEWAY_FILTER_EN, when defined, SHALL compile in a per-source glitch filter between s[n] and f[n].
REQ-028 With the macro defined, f[n] SHALL change only after s[n] has differed from f[n] for FilterCycles consecutive cycles.
REQ-029 Filter counter: 8 bits; it SHALL reset to 0 whenever s[n] == f[n] and saturate at FilterCycles.
REQ-030 This adds FilterCycles cycles of latency in both directions; shorter pulses are dropped.
REQ-031 With the macro undefined, no counters SHALL be instantiated and REQ-012 applies.

Verification
REQ-032 Level, filter off, SyncStages=2: irq_i[1] rises at cycle 0 -> interrupts_o[1] high at cycle 3; irq_i[1] falls -> interrupts_o[1] low 3 cycles later.
REQ-033 Edge: irq_i[3] 0->1 and held -> interrupts_o[3] high and held while irq_i stays high; ack_i[3] pulse -> interrupts_o[3] low next cycle and stays low.
REQ-034 Edge: second rising edge on irq_i[4] lands in the same cycle as ack_i[4] -> interrupts_o[4] remains 1; a later ack_i[4] alone clears it.
REQ-035 Reset: rst_i high for 1 cycle while pending[5]=1 and irq_i[6] (level) is high -> all outputs 0 next cycle; interrupts_o[6] returns 3 cycles after rst_i falls.
REQ-036 IRQ_GATEWAY_FILTER_EN defined, FilterCycles=4: 3-cycle high pulse on irq_i[2] -> interrupts_o[2] never asserts; 10-cycle pulse -> asserts SyncStages+4+1 cycles after the rising edge.
REQ-037 edge_trigger_o == 0 in every cycle of every scenario; ack_i on level source 1 -> interrupts_o[1] unchanged.
